// File: rtl/sampler_dma_pkg.sv
// Shared field positions, FSM encoding and AXI constants for the sampler voice DMA.
// Register-block word layouts live here so the engine and its users agree on them.
package sampler_dma_pkg;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_STOP_BIT  = 1;
    localparam int CTRL_LEN_LSB   = 8;
    localparam int CTRL_LEN_MSB   = 31;

    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_DONE_BIT  = 1;
    localparam int STAT_ERROR_BIT = 2;
    localparam int STAT_COUNT_LSB = 8;
    localparam int STAT_COUNT_MSB = 31;

    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SPACE,
        ADDR,
        DATA,
        FINISH
    } dma_state_t;

endpackage

// File: rtl/sampler_dma_fifo.sv
// Sample FIFO: push/pop/flush, head word held in a register (valid the cycle after a push into an empty FIFO).
// Latency 1 cycle push-to-head; caller must not push when o_free_count is 0; flush drops all contents.
module sampler_dma_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_dat,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [WIDTH-1:0]         o_head_dat,
    output logic                     o_head_vld,
    output logic [$clog2(DEPTH):0]   o_free_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_mem_cnt;
    logic [WIDTH-1:0] r_head_dat;
    logic             r_head_vld;

    logic w_take;
    logic w_mem_empty;
    logic w_mem_rd;
    logic w_mem_wr;

    // The head register refills whenever it is empty or being consumed; a push
    // into a fully empty FIFO bypasses the array and lands on the head directly.
    assign w_take      = !r_head_vld || i_pop;
    assign w_mem_empty = (r_mem_cnt == '0);
    assign w_mem_rd    = w_take && !w_mem_empty;
    assign w_mem_wr    = i_push && !(w_take && w_mem_empty);

    always_ff @(posedge i_clk) begin
        if (w_mem_wr && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_mem_cnt  <= '0;
            r_head_dat <= '0;
            r_head_vld <= 1'b0;
        end else if (i_flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_mem_cnt  <= '0;
            r_head_vld <= 1'b0;
        end else begin
            if (w_mem_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_mem_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_mem_wr, w_mem_rd})
                2'b10:   r_mem_cnt <= r_mem_cnt + (AW+1)'(1);
                2'b01:   r_mem_cnt <= r_mem_cnt - (AW+1)'(1);
                default: r_mem_cnt <= r_mem_cnt;
            endcase
            if (w_take) begin
                if (w_mem_rd) begin
                    r_head_dat <= r_mem[r_rd_ptr];
                    r_head_vld <= 1'b1;
                end else if (i_push) begin
                    r_head_dat <= i_push_dat;
                    r_head_vld <= 1'b1;
                end else begin
                    r_head_vld <= 1'b0;
                end
            end
        end
    end

    assign o_head_dat   = r_head_dat;
    assign o_head_vld   = r_head_vld;
    assign o_free_count = (AW+1)'(DEPTH) - r_mem_cnt - {{AW{1'b0}}, r_head_vld};

endmodule

// File: rtl/sampler_dma_voice_engine.sv
// Per-voice read DMA: fetches LENGTH words from DDR in bursts of up to BURST_LEN and streams them to the mixer.
// Start latency: BUSY one cycle after the START edge, ARVALID one cycle later; bursts wait until the FIFO can absorb them.
module sampler_dma_voice_engine
    import sampler_dma_pkg::*;
#(
    parameter int BURST_LEN  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        axi_clk,
    input  logic        axi_reset,
    input  logic [31:0] dma_control,
    input  logic [31:0] dma_base_addr,
    output logic [31:0] dma_status,
    output logic [31:0] dma_curr_addr,
    output logic [31:0] m_axi_araddr,
    output logic [7:0]  m_axi_arlen,
    output logic [2:0]  m_axi_arsize,
    output logic [1:0]  m_axi_arburst,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rlast,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    output logic [31:0] sample_data,
    output logic        sample_valid,
    input  logic        sample_ready
);
    localparam int          BW        = $clog2(BURST_LEN) + 1;
    localparam int          FW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] ADDR_MASK = ~32'(BURST_LEN * 4 - 1);

    dma_state_t     r_state;
    dma_state_t     w_state_nxt;
    logic           r_start_prev;
    logic [23:0]    r_remaining;
    logic [31:0]    r_curr_addr;
    logic [23:0]    r_count;
    logic           r_busy;
    logic           r_done;
    logic           r_error;
    logic           r_stopped;
    logic           r_arvalid;
    logic [31:0]    r_araddr;
    logic [7:0]     r_arlen;
    logic           r_rready;
    logic [BW-1:0]  r_burst;

    logic           w_start_edge;
    logic           w_stop;
    logic [23:0]    w_len;
    logic [BW-1:0]  w_burst;
    logic [FW-1:0]  w_free;
    logic           w_space_ok;
    logic           w_beat;
    logic           w_last;
    logic           w_bad_resp;
    logic           w_flush;
    logic [5:0]     w_unused_ctrl;

    assign w_start_edge  = dma_control[CTRL_START_BIT] && !r_start_prev;
    assign w_stop        = dma_control[CTRL_STOP_BIT];
    assign w_len         = dma_control[CTRL_LEN_MSB:CTRL_LEN_LSB];
    assign w_unused_ctrl = dma_control[7:2];
    assign w_burst       = (r_remaining < 24'(BURST_LEN)) ? r_remaining[BW-1:0] : BW'(BURST_LEN);
    assign w_space_ok    = 32'(w_free) >= 32'(w_burst);
    assign w_beat        = m_axi_rvalid && r_rready;
    assign w_last        = w_beat && m_axi_rlast;
    assign w_bad_resp    = m_axi_rresp != AXI_RESP_OKAY;
    assign w_flush       = (r_state == FINISH) && r_stopped;

    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_start_edge) begin
                    w_state_nxt = (w_len == '0) ? FINISH : WAIT_SPACE;
                end
            end
            WAIT_SPACE: begin
                if (w_stop) begin
                    w_state_nxt = FINISH;
                end else if (w_space_ok) begin
                    w_state_nxt = ADDR;
                end
            end
            ADDR: begin
                if (r_arvalid && m_axi_arready) begin
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_last) begin
                    w_state_nxt = (r_remaining == '0 || r_error || w_bad_resp || w_stop)
                                  ? FINISH : WAIT_SPACE;
                end
            end
            FINISH:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            r_start_prev <= 1'b0;
            r_remaining  <= '0;
            r_curr_addr  <= '0;
            r_count      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_stopped    <= 1'b0;
            r_arvalid    <= 1'b0;
            r_araddr     <= '0;
            r_arlen      <= '0;
            r_rready     <= 1'b0;
            r_burst      <= '0;
        end else begin
            // Edge detector runs in every state so a held START cannot retrigger.
            r_start_prev <= dma_control[CTRL_START_BIT];
            case (r_state)
                IDLE: begin
                    if (w_start_edge) begin
                        r_remaining <= w_len;
                        r_curr_addr <= dma_base_addr & ADDR_MASK;
                        r_count     <= '0;
                        r_done      <= 1'b0;
                        r_error     <= 1'b0;
                        r_stopped   <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                WAIT_SPACE: begin
                    if (w_stop) begin
                        r_stopped <= 1'b1;
                    end else if (w_space_ok) begin
                        r_arvalid <= 1'b1;
                        r_araddr  <= r_curr_addr;
                        r_arlen   <= 8'(w_burst) - 8'd1;
                        r_burst   <= w_burst;
                    end
                end
                ADDR: begin
                    if (r_arvalid && m_axi_arready) begin
                        r_arvalid   <= 1'b0;
                        r_curr_addr <= r_curr_addr + (32'(r_burst) << 2);
                        r_remaining <= r_remaining - 24'(r_burst);
                        r_rready    <= 1'b1;
                    end
                end
                DATA: begin
                    if (w_beat) begin
                        r_count <= r_count + 24'd1;
                        if (w_bad_resp) begin
                            r_error <= 1'b1;
                        end
                    end
                    if (w_last) begin
                        r_rready <= 1'b0;
                        if (w_stop) begin
                            r_stopped <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    sampler_dma_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .i_clk        (axi_clk),
        .i_rst        (axi_reset),
        .i_push       (w_beat),
        .i_push_dat   (m_axi_rdata),
        .i_pop        (sample_ready),
        .i_flush      (w_flush),
        .o_head_dat   (sample_data),
        .o_head_vld   (sample_valid),
        .o_free_count (w_free)
    );

    always_comb begin
        dma_status                                = '0;
        dma_status[STAT_BUSY_BIT]                 = r_busy;
        dma_status[STAT_DONE_BIT]                 = r_done;
        dma_status[STAT_ERROR_BIT]                = r_error;
        dma_status[STAT_COUNT_MSB:STAT_COUNT_LSB] = r_count;
    end

    assign dma_curr_addr = r_curr_addr;
    assign m_axi_araddr  = r_araddr;
    assign m_axi_arlen   = r_arlen;
    assign m_axi_arsize  = AXI_SIZE_4B;
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = r_rready;

endmodule

// File: tb/tb_sampler_dma_voice_engine.sv
// Bench for the voice DMA: randomized AXI slave and mixer sink, checked against a burst-plan model.
// Directed scenarios cover latency, backpressure, STOP, error response, zero length and reset.
module tb_sampler_dma_voice_engine;
    localparam int BL = 8;
    localparam int FD = 16;

    logic        axi_clk = 1'b0;
    logic        axi_reset;
    logic [31:0] dma_control;
    logic [31:0] dma_base_addr;
    logic [31:0] dma_status;
    logic [31:0] dma_curr_addr;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic [31:0] sample_data;
    logic        sample_valid;
    logic        sample_ready;

    always #5 axi_clk = ~axi_clk;

    sampler_dma_voice_engine #(.BURST_LEN(BL), .FIFO_DEPTH(FD)) dut (
        .axi_clk       (axi_clk),
        .axi_reset     (axi_reset),
        .dma_control   (dma_control),
        .dma_base_addr (dma_base_addr),
        .dma_status    (dma_status),
        .dma_curr_addr (dma_curr_addr),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .sample_data   (sample_data),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] g_seed;
    logic [39:0] exp_ar[$];
    logic [31:0] exp_dat[$];
    int          exp_cnt;
    logic [31:0] exp_addr;
    int          ar_count;
    int          s_bno;
    int          err_bno  = 0;
    int          err_beat = 0;
    int          sink_mode = 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ g_seed;
    endfunction

    // Reference plan: which bursts should be requested and which words streamed.
    task automatic plan(input logic [31:0] base, input int len, input int max_b);
        logic [31:0] a;
        int rem, nb, b;
        a = base & ~32'(BL * 4 - 1);
        rem = len;
        nb = 0;
        exp_ar.delete();
        exp_dat.delete();
        exp_cnt = 0;
        while (rem > 0 && nb < max_b) begin
            b = (rem < BL) ? rem : BL;
            exp_ar.push_back({a, 8'(b - 1)});
            for (int i = 0; i < b; i++) exp_dat.push_back(mem_word(a + 32'(4 * i)));
            a += 32'(4 * b);
            rem -= b;
            nb++;
            exp_cnt += b;
        end
        exp_addr = a;
        ar_count = 0;
        s_bno = 0;
    endtask

    task automatic start_dma(input logic [31:0] base, input int len);
        dma_base_addr = base;
        dma_control   = {24'(len), 8'h00};
        @(negedge axi_clk);
        dma_control[0] = 1'b1;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        @(negedge axi_clk);
        while (!(dma_status[1] && !dma_status[0]) && n < budget) begin
            @(negedge axi_clk);
            n++;
        end
        chk("done", {30'b0, dma_status[1:0]}, 32'h2);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_dat.size() != 0 && n < budget) begin
            @(negedge axi_clk);
            n++;
        end
        chk("drain", 32'(exp_dat.size()), 32'd0);
    endtask

    task automatic run_job(input logic [31:0] base, input int len, input int max_b,
                           input logic [31:0] flags);
        plan(base, len, max_b);
        start_dma(base, len);
        wait_done(3000);
        wait_drain(3000);
        chk("job_status", dma_status, (32'(exp_cnt) << 8) | flags);
        chk("job_addr", dma_curr_addr, exp_addr);
        chk("job_ar_left", 32'(exp_ar.size()), 32'd0);
    endtask

    // AXI slave and mixer sink; inputs change on the falling edge, handshakes land on the next rising edge.
    initial begin
        int s_left, s_bidx;
        logic [31:0] s_addr, cap_addr, e;
        logic [7:0] cap_len;
        logic [39:0] ea;
        bit ar_p, r_p;
        s_left = 0; s_bidx = 0; s_addr = 0; ar_p = 0; r_p = 0;
        cap_addr = 0; cap_len = 0;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rdata = 0; m_axi_rresp = 0;
        sample_ready = 0;
        forever begin
            @(negedge axi_clk);
            if (axi_reset) begin
                s_left = 0; ar_p = 0; r_p = 0;
                m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rresp = 0;
                sample_ready = 0;
                continue;
            end
            if (ar_p) begin
                ar_count++;
                ea = (exp_ar.size() != 0) ? exp_ar.pop_front() : 40'hFF_FFFF_FFFF;
                chk("ar_addr", cap_addr, ea[39:8]);
                chk("ar_len", {24'b0, cap_len}, {24'b0, ea[7:0]});
                s_addr = cap_addr;
                s_left = int'(cap_len) + 1;
                s_bno++;
                s_bidx = 0;
            end
            if (r_p) begin
                if (s_bno == 1 && s_bidx == 0) begin
                    chk("fwft_vld", {31'b0, sample_valid}, 32'd1);
                    chk("fwft_dat", sample_data, mem_word(s_addr));
                end
                s_addr += 4;
                s_left--;
                s_bidx++;
            end
            m_axi_arready = (s_left == 0) ? ($urandom_range(0, 2) != 0) : 1'b0;
            if (!(m_axi_rvalid && !r_p)) begin
                if (s_left > 0 && $urandom_range(0, 3) != 0) begin
                    m_axi_rvalid = 1'b1;
                    m_axi_rdata  = mem_word(s_addr);
                    m_axi_rlast  = (s_left == 1);
                    m_axi_rresp  = (s_bno == err_bno && s_bidx == err_beat - 1) ? 2'b10 : 2'b00;
                end else begin
                    m_axi_rvalid = 1'b0;
                    m_axi_rlast  = 1'b0;
                    m_axi_rresp  = 2'b00;
                end
            end
            sample_ready = (sink_mode == 1) ? 1'b1 :
                           (sink_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
            if (sample_valid && sample_ready) begin
                e = (exp_dat.size() != 0) ? exp_dat.pop_front() : ~sample_data;
                chk("sample", sample_data, e);
            end
            ar_p = m_axi_arvalid && m_axi_arready;
            cap_addr = m_axi_araddr;
            cap_len = m_axi_arlen;
            r_p = m_axi_rvalid && m_axi_rready;
        end
    end

    initial begin
        int n;
        g_seed = $urandom;
        axi_reset = 1'b1;
        dma_control = '0;
        dma_base_addr = '0;
        repeat (3) @(negedge axi_clk);
        axi_reset = 1'b0;
        @(negedge axi_clk);
        chk("rst_status", dma_status, 32'h0);
        chk("rst_curr", dma_curr_addr, 32'h0);
        chk("rst_arvalid", {31'b0, m_axi_arvalid}, 32'd0);
        chk("rst_arlen", {24'b0, m_axi_arlen}, 32'd0);
        chk("rst_araddr", m_axi_araddr, 32'h0);
        chk("rst_rready", {31'b0, m_axi_rready}, 32'd0);
        chk("rst_svalid", {31'b0, sample_valid}, 32'd0);

        // Basic run with latency probes and a START re-edge while busy.
        sink_mode = 1;
        plan(32'h1000, 20, 99);
        start_dma(32'h1000, 20);
        @(negedge axi_clk);
        chk("lat_busy", dma_status, 32'h1);
        chk("lat_arv_n", {31'b0, m_axi_arvalid}, 32'd0);
        @(negedge axi_clk);
        chk("lat_arv_n1", {31'b0, m_axi_arvalid}, 32'd1);
        dma_control[0] = 1'b0;
        @(negedge axi_clk);
        dma_control[0] = 1'b1;
        wait_done(1000);
        wait_drain(1000);
        chk("t1_status", dma_status, 32'h1402);
        chk("t1_curr", dma_curr_addr, 32'h1050);
        chk("t1_ar_count", 32'(ar_count), 32'd3);
        repeat (5) @(negedge axi_clk);
        chk("held_start_status", dma_status, 32'h1402);
        chk("held_start_ars", 32'(ar_count), 32'd3);

        // Backpressure: FIFO fills after two bursts, then resumes.
        sink_mode = 2;
        plan(32'h2000, 40, 99);
        start_dma(32'h2000, 40);
        n = 0;
        while (dma_status[31:8] != 24'd16 && n < 500) begin
            @(negedge axi_clk);
            n++;
        end
        repeat (20) @(negedge axi_clk);
        chk("bp_ar_count", 32'(ar_count), 32'd2);
        chk("bp_arvalid", {31'b0, m_axi_arvalid}, 32'd0);
        chk("bp_status", dma_status, 32'h1001);
        chk("bp_head", sample_data, mem_word(32'h2000));
        sink_mode = 0;
        wait_done(2000);
        wait_drain(2000);
        chk("bp_final", dma_status, 32'h2802);
        chk("bp_curr", dma_curr_addr, 32'h20A0);
        chk("bp_ar_total", 32'(ar_count), 32'd5);

        // STOP during the second burst's data phase.
        sink_mode = 2;
        plan(32'h3000, 40, 99);
        start_dma(32'h3000, 40);
        n = 0;
        while (ar_count < 2 && n < 500) begin
            @(negedge axi_clk);
            n++;
        end
        dma_control[1] = 1'b1;
        wait_done(500);
        repeat (3) @(negedge axi_clk);
        chk("stop_status", dma_status, 32'h1002);
        chk("stop_ar_count", 32'(ar_count), 32'd2);
        chk("stop_flushed", {31'b0, sample_valid}, 32'd0);
        chk("stop_curr", dma_curr_addr, 32'h3040);
        dma_control[1] = 1'b0;
        exp_ar.delete();
        exp_dat.delete();

        // Error response on beat 3 of the first burst.
        sink_mode = 0;
        err_bno = 1;
        err_beat = 3;
        run_job(32'h7000, 24, 1, 32'h6);
        chk("err_ar_count", 32'(ar_count), 32'd1);
        err_bno = 0;

        // Zero length: DONE two cycles after the edge, no bus traffic.
        plan(32'h4000, 0, 99);
        start_dma(32'h4000, 0);
        @(negedge axi_clk);
        chk("zero_busy", dma_status, 32'h1);
        @(negedge axi_clk);
        chk("zero_done", dma_status, 32'h2);
        repeat (3) @(negedge axi_clk);
        chk("zero_ars", 32'(ar_count), 32'd0);
        chk("zero_curr", dma_curr_addr, 32'h4000);

        // Randomized jobs, including an address-wrap case.
        run_job(32'hFFFF_FFC4, 24, 99, 32'h2);
        for (int t = 0; t < 6; t++) begin
            sink_mode = (t % 3 == 0) ? 1 : 0;
            run_job($urandom, int'($urandom_range(1, 70)), 99, 32'h2);
        end

        // Reset while ARVALID is high with words buffered.
        sink_mode = 2;
        plan(32'h5000, 40, 99);
        start_dma(32'h5000, 40);
        n = 0;
        while (!(ar_count >= 1 && m_axi_arvalid) && n < 500) begin
            @(negedge axi_clk);
            n++;
        end
        chk("rst_mid_arv_seen", {31'b0, m_axi_arvalid}, 32'd1);
        dma_control = '0;
        axi_reset = 1'b1;
        #1;
        chk("rst_mid_arvalid", {31'b0, m_axi_arvalid}, 32'd0);
        chk("rst_mid_status", dma_status, 32'h0);
        chk("rst_mid_curr", dma_curr_addr, 32'h0);
        chk("rst_mid_fifo", {31'b0, sample_valid}, 32'd0);
        repeat (2) @(negedge axi_clk);
        axi_reset = 1'b0;
        sink_mode = 0;
        @(negedge axi_clk);
        run_job(32'h6000, 5, 99, 32'h2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sampler_dma_voice_engine.md
# sampler_dma_voice_engine

Per-voice read-DMA engine for the sampler. It consumes the per-voice `dma_control` and `dma_base_addr` words from the sampler DMA register block and fetches sample words from DDR over an AXI4 read-master port into a local FIFO. It streams those words to the voice mixer over a valid/ready interface, and returns `dma_status` and `dma_curr_addr` to the register block. One instance exists per voice, MAX_VOICES instances in total.

## Interface
- BURST_LEN, 8: max beats per AXI burst; power of 2, at most 16.
- FIFO_DEPTH, 16: sample FIFO depth in words; power of 2, at least BURST_LEN.
- axi_clk  in  1  single clock for all logic.
- axi_reset  in  1  asynchronous, active-high reset.
- dma_control  in  32  bit0 START (rising edge starts), bit1 STOP (level), [31:8] LENGTH in 32-bit words.
- dma_base_addr  in  32  byte address; bits [log2(BURST_LEN*4)-1:0] are ignored and treated as 0.
- dma_status  out  32  bit0 BUSY, bit1 DONE, bit2 ERROR, [31:8] words written to FIFO.
- dma_curr_addr  out  32  byte address of the next burst to issue.
- m_axi_araddr  out  32, m_axi_arlen  out  8, m_axi_arvalid  out  1, m_axi_arready  in  1: read-address channel. ARSIZE=3'b010 and ARBURST=INCR are fixed.
- m_axi_rdata  in  32, m_axi_rresp  in  2, m_axi_rlast  in  1, m_axi_rvalid  in  1, m_axi_rready  out  1: read-data channel.
- sample_data  out  32, sample_valid  out  1, sample_ready  in  1: stream to the mixer.

## Operation
- FSM states: IDLE, WAIT_SPACE, ADDR, DATA, FINISH.
- IDLE
  - A START rising edge latches LENGTH into `remaining`, latches the masked base address into `curr_addr`, clears DONE, ERROR and the word count, and sets BUSY.
  - If LENGTH is 0, go to FINISH; otherwise go to WAIT_SPACE.
- WAIT_SPACE: go to ADDR when FIFO free slots are at least the next burst size, min(remaining, BURST_LEN).
- ADDR
  - `arvalid` is held with stable `araddr = curr_addr` and `arlen = burst-1` until `arready`. It is never withdrawn, even if STOP asserts.
  - On the handshake: `curr_addr += burst*4`, `remaining -= burst`, go to DATA.
- DATA
  - `rready = 1`; space is guaranteed by WAIT_SPACE.
  - Each accepted beat is pushed to the FIFO and the word count is incremented.
  - Any `rresp != 0` sets ERROR (sticky); the beat is still pushed.
  - On the `rlast` beat:
    - go to FINISH if `remaining == 0`, ERROR is set, or STOP is high;
    - otherwise go to WAIT_SPACE.
- FINISH
  - Clears BUSY and sets DONE.
  - If stopped by STOP, the FIFO is flushed in this cycle; on normal completion or ERROR, buffered words keep draining.
  - Returns to IDLE.
- STOP outside a burst: high in WAIT_SPACE goes to FINISH next cycle with a flush. STOP in IDLE has no effect.
- START edges while BUSY are ignored. The edge detector keeps running, so a START that is held high does not retrigger after FINISH.
- One burst is outstanding at most. Bursts never cross 4 KB because the base is burst-aligned and bursts are at most 64 B.
- Word count and `remaining` are 24 bits. `curr_addr` wraps modulo 2^32.

## Timing
- Reset values: `dma_status = 0`, `dma_curr_addr = 0`, `arvalid = 0`, `arlen = 0`, `araddr = 0`, `rready = 0`, `sample_valid = 0`; FSM in IDLE; FIFO empty.
- Start latency
  - START rising edge sampled at clock edge N (low at N-1).
  - BUSY is visible after edge N.
  - `arvalid` rises after edge N+1, provided the FIFO has space.
- Data to stream: an R beat accepted at edge M gives `sample_valid` after edge M, through a registered FIFO output (first-word-fall-through on the registered head).
- Simultaneous FIFO push and pop in the same cycle are both honoured; occupancy is unchanged.
- All outputs are registered.
- Asserting reset mid-burst aborts immediately. The AXI slave must be reset alongside.

## Structure
- `sampler_dma_pkg`
  - START/STOP bit indices and the LENGTH field range;
  - BUSY/DONE/ERROR bit indices and the COUNT field range;
  - `dma_state_t` enum;
  - AXI constants: SIZE_4B, BURST_INCR, RESP_OKAY.
- Sub-module `sampler_dma_fifo`: synchronous FIFO with push, pop, flush, `free_count`, registered head.

## Test plan
- base=0x1000, LENGTH=20, BURST_LEN=8, sink always ready:
  - ARs are (0x1000, len 7), (0x1020, len 7), (0x1040, len 3);
  - 20 words are streamed in order;
  - status ends at 0x1402 (COUNT=20, DONE); `curr_addr` = 0x1050.
- LENGTH=40, sample_ready=0:
  - two bursts fill the FIFO (16 words), then the engine stays in WAIT_SPACE with no AR;
  - releasing `sample_ready` resumes fetching.
- STOP asserted during the second burst's data phase:
  - the burst completes, no third AR is issued, the FIFO is flushed;
  - status = DONE with COUNT=16.
- `rresp = 2'b10` on beat 3 of burst 1, LENGTH=24:
  - ERROR and DONE are set after that burst; no further AR; COUNT=8.
- LENGTH=0 START: DONE after 2 cycles with no AR. A START edge while BUSY is ignored.
- `axi_reset` pulsed while `arvalid` is high: `arvalid`, `dma_status` and `curr_addr` read 0 immediately; the FIFO is empty.
